// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA adder sequencer.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_add_sequencer_cla.sv
// 4-bit carry-lookahead adder slice; all carries derived in parallel from generate/propagate.
import cla_seq_pkg::*;

module CarryLookAheadAdder (
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] S,
  output logic                Cout
);

  logic [NIBBLE_W-1:0] g_s;
  logic [NIBBLE_W-1:0] p_s;
  logic [NIBBLE_W-1:0] c_s;

  assign g_s = A & B;
  assign p_s = A ^ B;

  assign c_s[0] = Cin;
  assign c_s[1] = g_s[0] | (p_s[0] & Cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & Cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & Cin);
  assign Cout   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & Cin);

  assign S = p_s ^ c_s;

endmodule

// File: rtl/cla_add_sequencer.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice, one nibble per clock, LSB first.
// Optional signed-overflow output out_ovf is enabled by defining CLA_SEQ_OVF_EN.
import cla_seq_pkg::*;

module cla_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef CLA_SEQ_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  logic [WIDTH-1:0]      sum_q, sum_d;
  logic                  carry_q, carry_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [NIBBLE_W-1:0]   sl_a_s, sl_b_s, sl_s_s;
  logic                  sl_cout_s;
  logic                  last_s;

  assign sl_a_s = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign sl_b_s = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign last_s = (idx_q == IDXW'(NIB - 1));

  CarryLookAheadAdder u_slice (
    .A    (sl_a_s),
    .B    (sl_b_s),
    .Cin  (carry_q),
    .S    (sl_s_s),
    .Cout (sl_cout_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = sl_s_s;
        carry_d = sl_cout_s;
        // idx wraps to 0 on the final pass so it never leaves [0, NIB-1]
        if (last_s) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // Carry into the MSB is recovered from the top sum bit of the final slice.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == RUN && last_s) begin
      ovf_d = (sl_a_s[NIBBLE_W-1] ^ sl_b_s[NIBBLE_W-1] ^ sl_s_s[NIBBLE_W-1]) ^ sl_cout_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign out_ovf = ovf_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

endmodule
